// File: rtl/vga_timing_gen_pkg.sv
// Shared raster constants and types for the 720p timing generator and its
// consumers (display controller, DAC-side sync path).
package vga_timing_pkg;

   // Counter widths shared with the display controller
   localparam int H_W  = 11;
   localparam int V_W  = 10;
   localparam int FC_W = 8;

   // 1280x720@60 Hz timing, 74.25 MHz pixel clock
   localparam int H_ACTIVE_720P = 1280;
   localparam int H_FP_720P     = 110;
   localparam int H_SYNC_720P   = 40;
   localparam int H_BP_720P     = 220;
   localparam int V_ACTIVE_720P = 720;
   localparam int V_FP_720P     = 5;
   localparam int V_SYNC_720P   = 5;
   localparam int V_BP_720P     = 20;

   localparam int H_TOTAL_720P = H_ACTIVE_720P + H_FP_720P + H_SYNC_720P + H_BP_720P;
   localparam int V_TOTAL_720P = V_ACTIVE_720P + V_FP_720P + V_SYNC_720P + V_BP_720P;

   // Limits imposed by the counter widths and the sync pipe
   localparam int H_TOTAL_MAX    = 2048;
   localparam int V_TOTAL_MAX    = 1024;
   localparam int SYNC_DELAY_MAX = 3;

   // One stage of the DAC-side sync/blank pipe
   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
   } sync_bits_t;

   // Pattern driven while no video is being produced: syncs inactive, blanked
   function automatic sync_bits_t sync_idle(input bit pol);
      sync_bits_t s;
      s.hs      = ~pol;
      s.vs      = ~pol;
      s.blank_n = 1'b0;
      return s;
   endfunction

   // True when first <= pos < first+len
   function automatic logic in_window(input int pos, input int first, input int len);
      return (pos >= first) && (pos < first + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: counters and strobes for the display controller,
// delayed sync/blank for the video DAC.
interface vga_timing_gen_if;
   import vga_timing_pkg::*;

   logic [H_W-1:0]  h_counter;
   logic [V_W-1:0]  v_counter;
   logic            display_enable;
   logic            frame_start;
   logic            line_start;
   logic [FC_W-1:0] frame_count;
   logic            vga_hs;
   logic            vga_vs;
   logic            vga_blank_n;

   modport master (
      output h_counter, v_counter, display_enable, frame_start, line_start,
             frame_count, vga_hs, vga_vs, vga_blank_n
   );

   modport slave (
      input  h_counter, v_counter, display_enable, frame_start, line_start,
             frame_count, vga_hs, vga_vs, vga_blank_n
   );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// Parameterized-depth shift register for {hs, vs, blank_n}. A depth of zero
// passes the already-registered inputs straight through. The synchronous
// active-low clear loads every stage with the idle pattern.
module vga_sync_delay
   import vga_timing_pkg::*;
#(
   parameter int DEPTH    = 1,
   parameter bit SYNC_POL = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  sync_bits_t d,
   output sync_bits_t q
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;
      assign q = d;
   end else begin : g_pipe
      for (genvar g = 0; g < DEPTH; g++) begin : g_stage
         sync_bits_t q_r;
         sync_bits_t d_w;

         if (g == 0) begin : g_first
            assign d_w = d;
         end else begin : g_next
            assign d_w = g_stage[g-1].q_r;
         end

         // One pixel of delay; clear forces the idle pattern
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               q_r <= sync_idle(SYNC_POL);
            end else begin
               q_r <= d_w;
            end
         end
      end

      assign q = g_stage[DEPTH-1].q_r;
   end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing generator. Counters, display_enable and the
// frame/line strobes are registered together so they describe the same pixel;
// sync and blank for the DAC follow SYNC_DELAY cycles later.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE   = H_ACTIVE_720P,
   parameter int H_FP       = H_FP_720P,
   parameter int H_SYNC     = H_SYNC_720P,
   parameter int H_BP       = H_BP_720P,
   parameter int V_ACTIVE   = V_ACTIVE_720P,
   parameter int V_FP       = V_FP_720P,
   parameter int V_SYNC     = V_SYNC_720P,
   parameter int V_BP       = V_BP_720P,
   parameter bit SYNC_POL   = 1'b1,
   parameter int SYNC_DELAY = 1
) (
   input  logic             pixel_clk,
   input  logic             rst_n,
   vga_timing_gen_if.master vif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   if (H_TOTAL > H_TOTAL_MAX) begin : g_chk_h_total
      $error("vga_timing_gen: H_TOTAL %0d exceeds %0d", H_TOTAL, H_TOTAL_MAX);
   end
   if (V_TOTAL > V_TOTAL_MAX) begin : g_chk_v_total
      $error("vga_timing_gen: V_TOTAL %0d exceeds %0d", V_TOTAL, V_TOTAL_MAX);
   end
   if (SYNC_DELAY < 0 || SYNC_DELAY > SYNC_DELAY_MAX) begin : g_chk_delay
      $error("vga_timing_gen: SYNC_DELAY %0d outside 0..%0d", SYNC_DELAY, SYNC_DELAY_MAX);
   end

   localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
   localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);

   logic [H_W-1:0]  h_q, h_next;
   logic [V_W-1:0]  v_q, v_next;
   logic            de_q, de_next;
   logic            fs_q, fs_next;
   logic            ls_q, ls_next;
   logic            hs_q, hs_next;
   logic            vs_q, vs_next;
   logic [FC_W-1:0] fc_q;
   sync_bits_t      raw;
   sync_bits_t      dly;

   // Next raster position and everything decoded from it. Decoding the next
   // position lets all outputs be registered while staying aligned with the
   // counters they describe.
   always_comb begin
      h_next = h_q + 1'b1;
      v_next = v_q;
      if (h_q == H_LAST) begin
         h_next = '0;
         v_next = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end

      de_next = in_window(int'(h_next), 0, H_ACTIVE) && in_window(int'(v_next), 0, V_ACTIVE);
      hs_next = in_window(int'(h_next), H_ACTIVE + H_FP, H_SYNC) ? SYNC_POL : ~SYNC_POL;
      vs_next = in_window(int'(v_next), V_ACTIVE + V_FP, V_SYNC) ? SYNC_POL : ~SYNC_POL;
      ls_next = (h_next == '0);
      fs_next = (h_next == '0) && (v_next == '0);
   end

   // Raster counters, decoded qualifiers and frame counter
   always_ff @(posedge pixel_clk) begin
      if (!rst_n) begin
         h_q  <= H_LAST;
         v_q  <= V_LAST;
         de_q <= 1'b0;
         fs_q <= 1'b0;
         ls_q <= 1'b0;
         hs_q <= ~SYNC_POL;
         vs_q <= ~SYNC_POL;
         fc_q <= '0;
      end else begin
         h_q  <= h_next;
         v_q  <= v_next;
         de_q <= de_next;
         fs_q <= fs_next;
         ls_q <= ls_next;
         hs_q <= hs_next;
         vs_q <= vs_next;
         if (fs_next) begin
            fc_q <= fc_q + 1'b1;
         end
      end
   end

   assign raw = '{hs: hs_q, vs: vs_q, blank_n: de_q};

   vga_sync_delay #(
      .DEPTH    (SYNC_DELAY),
      .SYNC_POL (SYNC_POL)
   ) u_sync_delay (
      .clk   (pixel_clk),
      .rst_n (rst_n),
      .d     (raw),
      .q     (dly)
   );

   assign vif.h_counter      = h_q;
   assign vif.v_counter      = v_q;
   assign vif.display_enable = de_q;
   assign vif.frame_start    = fs_q;
   assign vif.line_start     = ls_q;
   assign vif.frame_count    = fc_q;
   assign vif.vga_hs         = dly.hs;
   assign vif.vga_vs         = dly.vs;
   assign vif.vga_blank_n    = dly.blank_n;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Raster timing generator for the 1280x720@60 Hz VGA output path. It produces the pixel coordinates `h_counter`/`v_counter` and the `display_enable` qualifier that the display controller consumes. It also produces the sync and blank signals for the video DAC, delayed to match the pixel pipeline, plus frame and line strobes and a frame counter for screen animations.

## Interface
- `H_ACTIVE`, 1280, visible pixels per line
- `H_FP`, 110, horizontal front porch (pixels)
- `H_SYNC`, 40, horizontal sync width (pixels)
- `H_BP`, 220, horizontal back porch (pixels)
- `V_ACTIVE`, 720, visible lines per frame
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, vertical sync width (lines)
- `V_BP`, 20, vertical back porch (lines)
- `SYNC_POL`, 1, active level of `vga_hs`/`vga_vs` (1 = active-high)
- `SYNC_DELAY`, 1, pipeline stages (0–3) on `vga_hs`/`vga_vs`/`vga_blank_n` relative to the counters
- `pixel_clk` in 1 pixel clock, 74.25 MHz; the only clock
- `rst_n` in 1 reset; synchronous, active-low
- `h_counter` out 11 current pixel column, 0..H_TOTAL-1
- `v_counter` out 10 current line, 0..V_TOTAL-1
- `display_enable` out 1 high when the current (h,v) is visible
- `frame_start` out 1 one-cycle pulse at (0,0)
- `line_start` out 1 one-cycle pulse whenever h_counter==0
- `frame_count` out 8 frame counter, wraps 255→0
- `vga_hs` out 1 horizontal sync to DAC, delayed by SYNC_DELAY
- `vga_vs` out 1 vertical sync to DAC, delayed by SYNC_DELAY
- `vga_blank_n` out 1 = display_enable delayed by SYNC_DELAY

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1650); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (750).
- Elaboration error if H_TOTAL>2048, V_TOTAL>1024, or SYNC_DELAY>3.
- `h_counter` increments every cycle. At H_TOTAL-1 it wraps to 0, and `v_counter` increments in that same cycle.
- `v_counter` wraps from V_TOTAL-1 to 0 only when h_counter also wraps.
- `display_enable` = (h<H_ACTIVE && v<V_ACTIVE).
- Raw hsync is active for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (1390..1429).
- Raw vsync is active for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (725..729). It covers whole lines and changes only at h=0.
- `frame_start` = (h==0 && v==0); `line_start` = (h==0).
- `frame_count` increments in the cycle `frame_start` is high. It wraps 255→0 with no flag.
- Delayed outputs come from a SYNC_DELAY-deep shift register of {hsync, vsync, display_enable}. With SYNC_DELAY=0 they are the same-cycle registered values.
- Reset, while rst_n is low at an edge:
  - h_counter=H_TOTAL-1 (1649), v_counter=V_TOTAL-1 (749), i.e. the last back-porch pixel.
  - display_enable=0, frame_start=0, line_start=0, frame_count=0.
  - vga_hs and vga_vs held at the inactive level (!SYNC_POL); all delay stages cleared to inactive; vga_blank_n=0.
- First edge after reset release: counters go to (0,0), display_enable=1, frame_start=1, line_start=1, frame_count=1.
- Reset asserted mid-frame: the next edge loads the reset values regardless of position. No partial-frame completion.

## Timing
- All outputs are registered. Counters, display_enable and the strobes are mutually aligned: each describes the same pixel in the same cycle.
- The display controller's combinational RGB is valid in the same cycle as the counters. One DAC-side RGB register is matched by SYNC_DELAY=1.
- vga_hs, vga_vs and vga_blank_n lag the counters by exactly SYNC_DELAY cycles.
- Line period: 1650 cycles. Frame period: 1,237,500 cycles. hsync width: 40 cycles. vsync width: 8250 cycles.
- No handshake; free-running. There is no stall input.

## Structure
- Package `vga_timing_pkg`: the 720p default timing constants, derived H_TOTAL/V_TOTAL, and the counter widths (11/10) shared with the display controller.
- One natural sub-module: `vga_sync_delay`, a parameterized-depth shift register for {hs, vs, blank_n} with a synchronous active-low clear to the inactive pattern.
- The counter/decode logic stays in the top module.

## Test plan
- Reset/release: hold rst_n low 10 cycles.
  - During reset: h=1649, v=749, de=0, vga_hs=vga_vs=0, blank_n=0, frame_count=0.
  - Next cycle after release: (0,0), de=1, frame_start=1, frame_count=1.
- Line wrap: at (1649,0) the next cycle shows (0,1) with line_start=1 and frame_start=0. de falls exactly at h=1280.
- Horizontal sync: the raw sync is high for exactly 40 cycles starting at h=1390. Measured with SYNC_DELAY=1, vga_hs rises at the edge after h_counter==1390. No sync pulse appears inside the active region.
- Frame: vga_vs is high for 8250 cycles covering v=725..729. frame_start pulses are spaced 1,237,500 cycles apart, and frame_count goes 255→0 on the 256th frame.
- SYNC_DELAY=2 build: vga_hs, vga_vs and vga_blank_n each lag their raw decode by exactly 2 cycles. vga_blank_n rises 2 cycles after (0,0).
- Mid-frame reset at (600,300): the next edge shows (1649,749), de=0, frame_count=0, delay pipe cleared. Release resumes at (0,0).
